// File: rtl/sw_cmd_pkg.sv
// sw_cmd_pkg: command encoding, switch bit indices and resolver helpers
package sw_cmd_pkg;
  typedef enum logic [1:0] {CMD_OFF = 2'd0, CMD_ON = 2'd1, CMD_CLEAN = 2'd2, CMD_EVADE = 2'd3} cmd_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;
  localparam int NUM_SW = 4;
  localparam int SW_OFF = 0;
  localparam int SW_ON = 1;
  localparam int SW_CLEAN = 2;
  localparam int SW_EVADE = 3;
  function automatic logic multi_hot(input logic [NUM_SW-1:0] v);
    return (v & (v - NUM_SW'(1))) != '0;
  endfunction
  function automatic cmd_e resolve(input logic [NUM_SW-1:0] v);
    return v[SW_OFF] ? CMD_OFF : v[SW_EVADE] ? CMD_EVADE : v[SW_CLEAN] ? CMD_CLEAN : v[SW_ON] ? CMD_ON : CMD_OFF;
  endfunction
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: one switch channel, two-flop synchroniser plus hold-time debounce
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic meta, sync;
  logic [CNT_W-1:0] cnt;
  // bring the asynchronous switch into the clk domain
  always_ff @(posedge clk or posedge rst)
    if (rst) {sync, meta} <= '0;
    else {sync, meta} <= {meta, raw};
  // accept a new level only after it has held for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      stable <= 1'b0;
    end else if (sync == stable) cnt <= '0;
    else if (cnt == LAST) begin
      stable <= sync;
      cnt <= '0;
    end else cnt <= cnt + 1'b1;
endmodule

// File: rtl/sw_cmd_conditioner.sv
// sw_cmd_conditioner: debounced switches resolved into a prioritised command with change strobe
module sw_cmd_conditioner
  import sw_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_stable,
  output logic [1:0]        cmd,
  output logic              cmd_active,
  output logic              cmd_valid,
  output logic              conflict
);
  state_e state, state_nx;
  cmd_e cmd_q, cmd_nx;
  logic valid_nx;
  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst(rst),
      .raw(sw_raw[i]),
      .stable(sw_stable[i])
    );
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      cmd_q <= CMD_OFF;
      cmd_valid <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state <= state_nx;
      cmd_q <= cmd_nx;
      cmd_valid <= valid_nx;
      conflict <= multi_hot(sw_stable);
    end
  // active whenever any debounced switch is up, idle once all are down
  always_comb state_nx = (sw_stable != '0) ? ST_ACTIVE : ST_IDLE;
  // next command and change strobe on the {active, cmd} pair
  always_comb begin
    cmd_nx = (state_nx == ST_ACTIVE) ? resolve(sw_stable) : CMD_OFF;
    valid_nx = {state_nx, cmd_nx} != {state, cmd_q};
  end
  assign cmd = cmd_q;
  assign cmd_active = (state == ST_ACTIVE);
endmodule

// File: tb/tb_sw_cmd_conditioner.sv
// tb_sw_cmd_conditioner: scoreboard bench for the switch command conditioner
module tb_sw_cmd_conditioner;
  import sw_cmd_pkg::*;
  typedef struct {
    int at;
    logic [1:0] cmd;
    logic act;
    logic conf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sw_raw = '0;
  logic [3:0] sw_stable;
  logic [1:0] cmd;
  logic cmd_active, cmd_valid, conflict;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int e, r;
  exp_t exp_q[$];
  exp_t got_e;

  sw_cmd_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .sw_raw(sw_raw),
    .sw_stable(sw_stable),
    .cmd(cmd),
    .cmd_active(cmd_active),
    .cmd_valid(cmd_valid),
    .conflict(conflict)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input int at, input logic [1:0] c, input logic act, input logic conf);
    exp_t x;
    x.at = at;
    x.cmd = c;
    x.act = act;
    x.conf = conf;
    exp_q.push_back(x);
  endtask

  // every strobe must match the oldest expected change
  always @(negedge clk)
    if (!rst && cmd_valid) begin
      if (exp_q.size() == 0) chk("spurious_strobe", {31'd0, cmd_valid}, 32'd0);
      else begin
        got_e = exp_q.pop_front();
        chk("strobe_cyc", cyc, got_e.at);
        chk("strobe_cmd", {30'd0, cmd}, {30'd0, got_e.cmd});
        chk("strobe_act", {31'd0, cmd_active}, {31'd0, got_e.act});
        chk("strobe_conf", {31'd0, conflict}, {31'd0, got_e.conf});
      end
    end

  initial begin
    tick();
    tick();
    chk("reset_outs", {sw_stable, cmd, cmd_active, cmd_valid, conflict}, 0);
    rst = 1'b0;
    repeat (20) tick();
    chk("idle_outs", {sw_stable, cmd, cmd_active, cmd_valid, conflict}, 0);
    // cleaning rises
    e = cyc;
    sw_raw[2] = 1'b1;
    push(e + 7, CMD_CLEAN, 1'b1, 1'b0);
    wait_to(e + 5);
    chk("clean_pre", sw_stable, 4'b0000);
    wait_to(e + 6);
    chk("clean_stable", sw_stable, 4'b0100);
    chk("clean_act_early", cmd_active, 1'b0);
    wait_to(e + 7);
    chk("clean_cmd", cmd, CMD_CLEAN);
    chk("clean_valid", cmd_valid, 1'b1);
    wait_to(e + 8);
    chk("clean_valid_drop", cmd_valid, 1'b0);
    // bounce on 'on' never gets through
    sw_raw[1] = 1'b1;
    repeat (3) tick();
    sw_raw[1] = 1'b0;
    tick();
    sw_raw[1] = 1'b1;
    repeat (3) tick();
    sw_raw[1] = 1'b0;
    repeat (12) begin
      tick();
      chk("bounce_stable", sw_stable, 4'b0100);
    end
    // evading over cleaning, then released
    e = cyc;
    sw_raw[3] = 1'b1;
    push(e + 7, CMD_EVADE, 1'b1, 1'b1);
    wait_to(e + 9);
    chk("evade_cmd", cmd, CMD_EVADE);
    chk("evade_conf", conflict, 1'b1);
    e = cyc;
    sw_raw[3] = 1'b0;
    push(e + 7, CMD_CLEAN, 1'b1, 1'b0);
    wait_to(e + 9);
    chk("back_clean_cmd", cmd, CMD_CLEAN);
    chk("back_clean_conf", conflict, 1'b0);
    // evading held alone, then power_off on top
    e = cyc;
    sw_raw[3] = 1'b1;
    push(e + 7, CMD_EVADE, 1'b1, 1'b1);
    wait_to(e + 9);
    e = cyc;
    sw_raw[2] = 1'b0;
    wait_to(e + 9);
    chk("evade_only_conf", conflict, 1'b0);
    chk("evade_only_cmd", cmd, CMD_EVADE);
    e = cyc;
    sw_raw[0] = 1'b1;
    push(e + 7, CMD_OFF, 1'b1, 1'b1);
    wait_to(e + 9);
    chk("off_cmd", cmd, CMD_OFF);
    chk("off_act", cmd_active, 1'b1);
    chk("off_conf", conflict, 1'b1);
    sw_raw[1] = 1'b1;
    repeat (10) tick();
    chk("on_under_off", sw_stable, 4'b1011);
    sw_raw[1] = 1'b0;
    repeat (10) tick();
    chk("on_gone", sw_stable, 4'b1001);
    chk("on_gone_cmd", cmd, CMD_OFF);
    // two channels drop together: one strobe to idle
    e = cyc;
    sw_raw = 4'b0000;
    push(e + 7, CMD_OFF, 1'b0, 1'b0);
    wait_to(e + 9);
    chk("all_low", {sw_stable, cmd_active, conflict}, 0);
    // reset mid-count discards progress
    e = cyc;
    sw_raw[3] = 1'b1;
    wait_to(e + 4);
    rst = 1'b1;
    #1;
    chk("rst_async", {sw_stable, cmd, cmd_active, cmd_valid, conflict}, 0);
    repeat (2) tick();
    rst = 1'b0;
    r = cyc;
    push(r + 7, CMD_EVADE, 1'b1, 1'b0);
    wait_to(r + 5);
    chk("post_rst_pre", sw_stable, 4'b0000);
    wait_to(r + 6);
    chk("post_rst_stable", sw_stable, 4'b1000);
    wait_to(r + 9);
    chk("post_rst_cmd", cmd, CMD_EVADE);
    repeat (10) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
